mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL: req_valid  in  1  controller requests a load/store.
REQ-004 SHALL: req_ready  out  1  unit can accept a request; high only in IDLE.
REQ-005 SHALL: req_write  in  1  1 = store, 0 = load.
REQ-006 SHALL: req_size  in  2  0 byte, 1 half, 2 word; 3 is treated as word.
REQ-007 SHALL: req_unsigned  in  1  loads zero-extend when 1, sign-extend when 0.
REQ-008 SHALL: req_addr  in  32  byte address.
REQ-009 SHALL: req_wdata  in  32  store data, right-aligned.
REQ-010 SHALL: resp_valid  out  1  one-cycle pulse when the access completes.
REQ-011 SHALL: resp_rdata  out  32  extended load data, valid with resp_valid; 0 for stores.
REQ-012 SHALL: bus_req / bus_we  out  1 each  bus request and write strobe.
REQ-013 SHALL: bus_addr  out  32  word address, bits [1:0] always 0.
REQ-014 SHALL: bus_be  out  4  byte enables, bit n = byte lane n.
REQ-015 SHALL: bus_wdata  out  32  lane-aligned store data.
REQ-016 SHALL: bus_ack  in  1  beat complete; bus_rdata  in  32  read data, valid with bus_ack.

Function
REQ-017 SHALL: implement FSM states IDLE, BEAT0, BEAT1, RESP.
REQ-018 SHALL: in IDLE, on req_valid=1, capture write, size, unsigned, addr and wdata, then go to BEAT0; all request inputs are ignored outside acceptance.
REQ-019 SHALL: in BEAT0 and BEAT1, hold bus_req=1 with stable bus_addr, bus_be, bus_we and bus_wdata until bus_ack=1; any number of wait cycles is allowed.
REQ-020 SHALL: when bus_req=0, drive bus_we, bus_addr, bus_be and bus_wdata to 0 and ignore bus_ack.
REQ-021 SHALL: define off = addr[1:0]; mask = 0001 (byte), 0011 (half), 1111 (word); span = mask shifted left by off, 8 bits.
REQ-022 SHALL: in BEAT0, drive bus_addr = {addr[31:2],00} and bus_be = span[3:0].
REQ-023 SHALL: require split = (span[7:4] != 0); on BEAT0 ack go to BEAT1 if split, else to RESP.
REQ-024 SHALL: in BEAT1, drive bus_addr = {addr[31:2],00}+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000), and bus_be = span[7:4]; on ack go to RESP.
REQ-025 SHALL: drive bus_wdata in both beats as wdata rotated left by 8*off bits.
REQ-026 SHALL: on each read ack, register bus_rdata as lo (BEAT0) or hi (BEAT1); raw = {hi,lo} shifted right by 8*off bits, lower 32 bits.
REQ-027 SHALL: form resp_rdata as raw[7:0] or raw[15:0], extended per req_unsigned, or raw[31:0] for word; form it from registered data in RESP.
REQ-028 SHALL: in RESP, assert resp_valid for exactly one cycle, then return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-029 SHALL: meet latency with zero-wait bus (ack in same cycle as bus_req): accept at T, BEAT0 at T+1, resp_valid at T+2; split accesses give resp_valid at T+3.
REQ-030 SHALL: hold resp_rdata at its last value outside RESP.

Reset
REQ-031 SHALL: on rst, force state IDLE and drive bus_req=0, resp_valid=0, resp_rdata=0, all bus outputs 0, and all capture registers 0; req_ready=1 once rst deasserts.
REQ-032 SHALL: abort an in-flight access when rst is asserted mid-beat, with no resp_valid and no further bus beats.

Verification
REQ-033 SHALL: cover aligned word load, addr 0x100, bus_rdata 0xDEADBEEF, zero-wait -> bus_be 1111, resp_valid at T+2, resp_rdata 0xDEADBEEF.
REQ-034 SHALL: cover signed byte load, addr 0x103, bus_rdata 0x80000000 -> bus_be 1000, resp_rdata 0xFFFFFF80; same with req_unsigned=1 -> 0x00000080.
REQ-035 SHALL: cover split word store, addr 0x202, wdata 0x11223344 -> beat0 addr 0x200, be 1100, wdata 0x33441122; beat1 addr 0x204, be 0011, same wdata; resp_valid at T+3.
REQ-036 SHALL: cover split half load at addr 0xFFFFFFFF, lo=0xAB000000, hi=0x000000CD, signed -> beat1 addr 0x00000000, resp_rdata 0xFFFFCDAB.
REQ-037 SHALL: cover 3 wait cycles in BEAT0 -> bus outputs stable throughout, exactly one resp_valid pulse; req_valid held high during access is not re-accepted.
REQ-038 SHALL: cover rst asserted during BEAT1 -> bus_req low immediately, no resp_valid, req_ready=1 after rst deasserts.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and memory bus signals of the access unit
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit splitting misaligned accesses into two word-bus beats
module mem_access_unit (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave mau
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
    localparam logic [1:0] BEAT1 = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]  state;
    logic        wr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] lo_q;
    logic [23:0] hi_q;
    logic [31:0] last_rdata_q;

    logic [1:0]  off;
    logic [3:0]  mask;
    logic [7:0]  span;
    logic        split;
    logic [31:0] rot_wdata;
    logic [31:0] raw;
    logic [31:0] ext;

    assign off   = addr_q[1:0];
    assign mask  = size_q[1] ? 4'b1111 : (size_q[0] ? 4'b0011 : 4'b0001);
    assign span  = {4'b0000, mask} << off;
    assign split = (span[7:4] != 4'b0000);

    always_comb begin
        rot_wdata = wdata_q;
        raw       = lo_q;
        case (off)
            2'd1: begin
                rot_wdata = {wdata_q[23:0], wdata_q[31:24]};
                raw       = {hi_q[7:0], lo_q[31:8]};
            end
            2'd2: begin
                rot_wdata = {wdata_q[15:0], wdata_q[31:16]};
                raw       = {hi_q[15:0], lo_q[31:16]};
            end
            2'd3: begin
                rot_wdata = {wdata_q[7:0], wdata_q[31:8]};
                raw       = {hi_q[23:0], lo_q[31:24]};
            end
            default: begin
                rot_wdata = wdata_q;
                raw       = lo_q;
            end
        endcase
    end

    // Stores report zero; size 3 falls through to the full word.
    always_comb begin
        ext = raw;
        if (wr_q) begin
            ext = 32'd0;
        end else if (size_q == 2'd0) begin
            ext = uns_q ? {24'd0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
        end else if (size_q == 2'd1) begin
            ext = uns_q ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
        end
    end

    always_comb begin
        mau.bus_req   = 1'b0;
        mau.bus_we    = 1'b0;
        mau.bus_addr  = 32'd0;
        mau.bus_be    = 4'd0;
        mau.bus_wdata = 32'd0;
        if (state == BEAT0 || state == BEAT1) begin
            mau.bus_req   = 1'b1;
            mau.bus_we    = wr_q;
            mau.bus_wdata = rot_wdata;
            mau.bus_addr  = {addr_q[31:2], 2'b00};
            mau.bus_be    = span[3:0];
            if (state == BEAT1) begin
                mau.bus_addr = {addr_q[31:2], 2'b00} + 32'd4;
                mau.bus_be   = span[7:4];
            end
        end
    end

    assign mau.req_ready  = (state == IDLE);
    assign mau.resp_valid = (state == RESP);
    assign mau.resp_rdata = (state == RESP) ? ext : last_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            lo_q         <= 32'd0;
            hi_q         <= 24'd0;
            last_rdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mau.req_valid) begin
                        wr_q    <= mau.req_write;
                        size_q  <= mau.req_size;
                        uns_q   <= mau.req_unsigned;
                        addr_q  <= mau.req_addr;
                        wdata_q <= mau.req_wdata;
                        lo_q    <= 32'd0;
                        hi_q    <= 24'd0;
                        state   <= BEAT0;
                    end
                end
                BEAT0: begin
                    if (mau.bus_ack) begin
                        if (!wr_q) lo_q <= mau.bus_rdata;
                        state <= split ? BEAT1 : RESP;
                    end
                end
                BEAT1: begin
                    // Only the low three bytes of the second word can reach the result.
                    if (mau.bus_ack) begin
                        if (!wr_q) hi_q <= mau.bus_rdata[23:0];
                        state <= RESP;
                    end
                end
                default: begin
                    last_rdata_q <= ext;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed vector bench for mem_access_unit
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mem_access_unit_if bif();

    mem_access_unit u_dut (
        .clk (clk),
        .rst (rst),
        .mau (bif.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        split;
        logic [31:0] addr0;
        logic [3:0]  be0;
        logic [31:0] addr1;
        logic [3:0]  be1;
        logic [31:0] bwdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                            input logic we, input logic [31:0] wd);
        chk({tag, ".bus_req"}, 32'(bif.bus_req), 32'd1);
        chk({tag, ".bus_addr"}, bif.bus_addr, a);
        chk({tag, ".bus_be"}, 32'(bif.bus_be), 32'(be));
        chk({tag, ".bus_we"}, 32'(bif.bus_we), 32'(we));
        chk({tag, ".bus_wdata"}, bif.bus_wdata, wd);
        chk({tag, ".resp_valid"}, 32'(bif.resp_valid), 32'd0);
        chk({tag, ".req_ready"}, 32'(bif.req_ready), 32'd0);
    endtask

    task automatic chk_bus_idle(input string tag);
        chk({tag, ".bus_req"}, 32'(bif.bus_req), 32'd0);
        chk({tag, ".bus_addr"}, bif.bus_addr, 32'd0);
        chk({tag, ".bus_be"}, 32'(bif.bus_be), 32'd0);
        chk({tag, ".bus_we"}, 32'(bif.bus_we), 32'd0);
        chk({tag, ".bus_wdata"}, bif.bus_wdata, 32'd0);
    endtask

    task automatic run_txn(input vec_t v, input int waits, input bit hold, input string tag);
        @(negedge clk);
        chk({tag, ".ready_idle"}, 32'(bif.req_ready), 32'd1);
        bif.req_write    = v.wr;
        bif.req_size     = v.size;
        bif.req_unsigned = v.uns;
        bif.req_addr     = v.addr;
        bif.req_wdata    = v.wdata;
        bif.req_valid    = 1'b1;
        @(posedge clk); #1;
        if (hold) begin
            bif.req_write    = ~v.wr;
            bif.req_addr     = ~v.addr;
            bif.req_wdata    = ~v.wdata;
            bif.req_unsigned = ~v.uns;
        end else begin
            bif.req_valid = 1'b0;
        end
        chk_beat({tag, ".b0"}, v.addr0, v.be0, v.wr, v.bwdata);
        for (int w = 0; w < waits; w++) begin
            bif.bus_ack = 1'b0;
            @(posedge clk); #1;
            chk_beat($sformatf("%s.b0w%0d", tag, w), v.addr0, v.be0, v.wr, v.bwdata);
        end
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = v.lo;
        @(posedge clk); #1;
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = 32'h5A5A5A5A;
        if (v.split) begin
            chk_beat({tag, ".b1"}, v.addr1, v.be1, v.wr, v.bwdata);
            bif.bus_ack   = 1'b1;
            bif.bus_rdata = v.hi;
            @(posedge clk); #1;
            bif.bus_ack   = 1'b0;
            bif.bus_rdata = 32'h5A5A5A5A;
        end
        chk({tag, ".resp_valid"}, 32'(bif.resp_valid), 32'd1);
        chk({tag, ".resp_rdata"}, bif.resp_rdata, v.rdata);
        chk({tag, ".resp_ready"}, 32'(bif.req_ready), 32'd0);
        chk_bus_idle({tag, ".resp"});
        bif.req_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".pulse_end"}, 32'(bif.resp_valid), 32'd0);
        chk({tag, ".rdata_hold"}, bif.resp_rdata, v.rdata);
        chk({tag, ".ready_after"}, 32'(bif.req_ready), 32'd1);
        chk_bus_idle({tag, ".after"});
    endtask

    initial begin
        //          wr  sz    un  addr          wdata         lo            hi            sp  addr0         be0      addr1         be1      bwdata        rdata
        vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h00000100, 32'h00000000, 32'hDEADBEEF, 32'h0,        1'b0, 32'h00000100, 4'b1111, 32'h0,        4'b0000, 32'h00000000, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h00000103, 32'h00000000, 32'h80000000, 32'h0,        1'b0, 32'h00000100, 4'b1000, 32'h0,        4'b0000, 32'h00000000, 32'hFFFFFF80};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h00000103, 32'h00000000, 32'h80000000, 32'h0,        1'b0, 32'h00000100, 4'b1000, 32'h0,        4'b0000, 32'h00000000, 32'h00000080};
        vecs[3]  = '{1'b1, 2'd2, 1'b0, 32'h00000202, 32'h11223344, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000200, 4'b1100, 32'h00000204, 4'b0011, 32'h33441122, 32'h00000000};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'hAB000000, 32'h000000CD, 1'b1, 32'hFFFFFFFC, 4'b1000, 32'h00000000, 4'b0001, 32'h00000000, 32'hFFFFCDAB};
        vecs[5]  = '{1'b1, 2'd1, 1'b0, 32'h00001001, 32'h0000BEEF, 32'h0,        32'h0,        1'b0, 32'h00001000, 4'b0110, 32'h0,        4'b0000, 32'h00BEEF00, 32'h00000000};
        vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h00000002, 32'h00000000, 32'h80010000, 32'h0,        1'b0, 32'h00000000, 4'b1100, 32'h0,        4'b0000, 32'h00000000, 32'h00008001};
        vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h00000002, 32'h00000000, 32'h80010000, 32'h0,        1'b0, 32'h00000000, 4'b1100, 32'h0,        4'b0000, 32'h00000000, 32'hFFFF8001};
        vecs[8]  = '{1'b0, 2'd3, 1'b0, 32'h00000000, 32'h00000000, 32'h12345678, 32'h0,        1'b0, 32'h00000000, 4'b1111, 32'h0,        4'b0000, 32'h00000000, 32'h12345678};
        vecs[9]  = '{1'b1, 2'd0, 1'b0, 32'h00000001, 32'hFFFFFFA5, 32'h0,        32'h0,        1'b0, 32'h00000000, 4'b0010, 32'h0,        4'b0000, 32'hFFFFA5FF, 32'h00000000};
        vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h00000003, 32'h00000000, 32'hAA000000, 32'h11CCBBDD, 1'b1, 32'h00000000, 4'b1000, 32'h00000004, 4'b0111, 32'h00000000, 32'hCCBBDDAA};
        vecs[11] = '{1'b0, 2'd0, 1'b0, 32'h00000002, 32'h00000000, 32'h007F0000, 32'h0,        1'b0, 32'h00000000, 4'b0100, 32'h0,        4'b0000, 32'h00000000, 32'h0000007F};

        bif.req_valid    = 1'b0;
        bif.req_write    = 1'b0;
        bif.req_size     = 2'd0;
        bif.req_unsigned = 1'b0;
        bif.req_addr     = 32'd0;
        bif.req_wdata    = 32'd0;
        bif.bus_ack      = 1'b0;
        bif.bus_rdata    = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.resp_valid", 32'(bif.resp_valid), 32'd0);
        chk("rst.resp_rdata", bif.resp_rdata, 32'd0);
        chk_bus_idle("rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.req_ready", 32'(bif.req_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i], 0, 1'b0, $sformatf("vec%0d", i));
        end

        // Three wait states in BEAT0 with req_valid held and request inputs changing.
        run_txn(vecs[7], 3, 1'b1, "wait3_hold");
        run_txn(vecs[10], 2, 1'b1, "wait2_split_hold");

        // Stray bus_ack while idle must be ignored.
        @(negedge clk);
        bif.bus_ack = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("idle_ack.resp_valid", 32'(bif.resp_valid), 32'd0);
            chk("idle_ack.ready", 32'(bif.req_ready), 32'd1);
            chk_bus_idle("idle_ack");
        end
        bif.bus_ack = 1'b0;

        // Reset during BEAT1 of a split access.
        @(negedge clk);
        bif.req_write    = vecs[4].wr;
        bif.req_size     = vecs[4].size;
        bif.req_unsigned = vecs[4].uns;
        bif.req_addr     = vecs[4].addr;
        bif.req_wdata    = vecs[4].wdata;
        bif.req_valid    = 1'b1;
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = vecs[4].lo;
        @(posedge clk); #1;
        bif.bus_ack = 1'b0;
        chk_beat("abort.b1", vecs[4].addr1, vecs[4].be1, 1'b0, 32'd0);
        rst = 1'b1;
        #1;
        chk_bus_idle("abort.rst");
        chk("abort.resp_valid", 32'(bif.resp_valid), 32'd0);
        chk("abort.resp_rdata", bif.resp_rdata, 32'd0);
        bif.bus_ack = 1'b1;
        @(posedge clk); #1;
        bif.bus_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort.post_valid", 32'(bif.resp_valid), 32'd0);
            chk("abort.post_ready", 32'(bif.req_ready), 32'd1);
            chk_bus_idle("abort.post");
        end

        run_txn(vecs[0], 0, 1'b0, "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
